// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning pipeline.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce_sync2.sv
// Two-flop synchroniser with a caller-supplied reset value, reusable for any pin input.
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= i_rst_val;
            r_sync <= i_rst_val;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debounces one raw button pin into a clean level plus press/release/long-press pulses.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000,
    parameter int unsigned ACTIVE_LOW        = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_in,
    output logic o_btn_level,
    output logic o_press,
    output logic o_release,
    output logic o_long_press
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam int unsigned HW = cnt_width(LONG_PRESS_CYCLES);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_FIRE = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] H_SAT  = HW'(LONG_PRESS_CYCLES);

    logic          w_inactive;
    logic          w_sync;
    logic          w_s;

    state_e        r_state;
    state_e        r_prev;
    state_e        w_state_nxt;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_nxt;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_nxt;
    logic          r_fired;

    logic          w_level;
    logic          w_press;
    logic          w_release;
    logic          w_long;

    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;

    assign w_inactive = (ACTIVE_LOW != 0);

    sync2 #(
        .WIDTH(1)
    ) u_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rst_val(w_inactive),
        .i_d      (i_btn_in),
        .o_q      (w_sync)
    );

    assign w_s = (ACTIVE_LOW != 0) ? ~w_sync : w_sync;

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_hcnt_nxt  = r_hcnt;
        case (r_state)
            IDLE: begin
                if (w_s) begin
                    w_state_nxt = PRESS_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_dcnt == D_LAST) begin
                    w_state_nxt = HELD;
                    w_hcnt_nxt  = '0;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            HELD: begin
                if (r_hcnt != H_SAT) begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
                if (!w_s) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_dcnt_nxt  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HELD;
                end else if (r_dcnt == D_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt + DW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Pulses are decoded from the registered state and its previous value, so a
    // bounce back from RELEASE_WAIT into HELD never looks like a fresh press.
    always_comb begin
        w_level   = (r_state == HELD) || (r_state == RELEASE_WAIT);
        w_press   = (r_state == HELD) && (r_prev == PRESS_WAIT);
        w_release = (r_state == IDLE) && (r_prev == RELEASE_WAIT);
        w_long    = (r_state == HELD) && (r_hcnt == H_FIRE) && !r_fired;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_prev    <= IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_fired   <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= r_state;
            r_dcnt    <= w_dcnt_nxt;
            r_hcnt    <= w_hcnt_nxt;
            r_level   <= w_level;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
            if (r_state == IDLE) begin
                r_fired <= 1'b0;
            end else if (w_long) begin
                r_fired <= 1'b1;
            end
        end
    end

    assign o_btn_level  = r_level;
    assign o_press      = r_press;
    assign o_release    = r_release;
    assign o_long_press = r_long;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, active-low pin.
module tb_button_debounce;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic lvl;
    logic prs;
    logic rel;
    logic lng;

    int vectors = 0;
    int miscompares = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_LOW       (1)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_btn_in    (btn),
        .o_btn_level (lvl),
        .o_press     (prs),
        .o_release   (rel),
        .o_long_press(lng)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int idx, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input int idx,
                          input logic e_lvl, input logic e_prs,
                          input logic e_rel, input logic e_lng);
        chk1({tag, ".level"}, idx, lvl, e_lvl);
        chk1({tag, ".press"}, idx, prs, e_prs);
        chk1({tag, ".release"}, idx, rel, e_rel);
        chk1({tag, ".long"}, idx, lng, e_lng);
    endtask

    initial begin
        rst = 1'b1;
        btn = 1'b1;
        tick();
        tick();
        check4("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Idle pin level for 50 cycles
        for (int i = 1; i <= 50; i++) begin
            tick();
            check4("idle", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Press and hold: press at +7, long_press at +26 from the first sampled edge
        btn = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            check4("hold", i, (i >= 8), (i == 8), 1'b0, (i == 27));
        end

        // Two-cycle bounce while held
        for (int i = 1; i <= 14; i++) begin
            btn = (i <= 2) ? 1'b1 : 1'b0;
            tick();
            check4("bounce", i, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // Release after the long press
        btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check4("rel1", i, (i < 8), 1'b0, (i == 8), 1'b0);
        end

        // Three-cycle glitch is rejected
        for (int i = 1; i <= 15; i++) begin
            btn = (i <= 3) ? 1'b0 : 1'b1;
            tick();
            check4("glitch", i, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Short press: accepted at 8, released at 18, release pulse at 25
        for (int i = 1; i <= 30; i++) begin
            btn = (i < 18) ? 1'b0 : 1'b1;
            tick();
            check4("short", i, (i >= 8 && i < 25), (i == 8), (i == 25), 1'b0);
        end

        // Reset while held, then a fresh press with the pin still active
        btn = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check4("prerst", i, (i >= 8), (i == 8), 1'b0, 1'b0);
        end
        rst = 1'b1;
        tick();
        check4("rst_held", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check4("postrst", i, (i >= 8), (i == 8), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Input-side counterpart to the LED blink outputs: conditions one raw, bouncy push-button pin into a clean level plus single-cycle event pulses.
- Pipeline: two-flop synchroniser, then a debounce state machine with a shared cycle counter, then a hold-time counter for long-press detection.
- Sits in the core clock domain next to the blink instances. One instance per board button.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised samples needed to accept a press or a release (10 ms at 100 MHz). Legal range is 2 or more.
- LONG_PRESS_CYCLES, 100000000: clock cycles in HELD, counted from press acceptance, before long_press fires (1 s at 100 MHz). Must be greater than DEBOUNCE_CYCLES.
- ACTIVE_LOW, 1: 1 means the pin reads 0 when pressed, and the input is inverted after synchronisation. 0 means active-high.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- btn_in  in  1  raw asynchronous button pin
- btn_level  out  1  debounced pressed level, 1 = pressed
- press  out  1  one-cycle pulse on an accepted press
- release  out  1  one-cycle pulse on an accepted release
- long_press  out  1  one-cycle pulse, at most once per press

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous, active-high.
- Reset, on the rst edge:
  - Synchroniser flops load the inactive pin level (1 if ACTIVE_LOW, else 0).
  - State goes to IDLE; both counters clear.
  - btn_level, press, release and long_press are all 0 on the cycle after rst is sampled.
- Reset mid-press discards all progress and emits no release pulse.
- Synchroniser: two flops, then polarity normalisation. Call the result s.
- Counters:
  - Debounce counter dcnt is sized for DEBOUNCE_CYCLES−1. Hold counter hcnt is sized for LONG_PRESS_CYCLES.
  - Both are unsigned and saturate; they never wrap.
- State machine:
  - IDLE: if s=1, go to PRESS_WAIT with dcnt=0.
  - PRESS_WAIT:
    - if s=0, go to IDLE (glitch rejected, no outputs);
    - else if dcnt=DEBOUNCE_CYCLES−1, go to HELD and clear hcnt;
    - else increment dcnt.
  - HELD:
    - if s=0, go to RELEASE_WAIT with dcnt=0;
    - hcnt increments every HELD cycle until saturation.
  - RELEASE_WAIT:
    - if s=1, return to HELD (bounce rejected; no press pulse, hcnt keeps its value);
    - else if dcnt=DEBOUNCE_CYCLES−1, go to IDLE;
    - else increment dcnt.
- Outputs (all registered):
  - btn_level = 1 exactly while in HELD or RELEASE_WAIT.
  - press = 1 for the single cycle following the PRESS_WAIT→HELD transition.
  - release = 1 for the single cycle following the RELEASE_WAIT→IDLE transition.
  - long_press = 1 for one cycle when hcnt reaches LONG_PRESS_CYCLES−1 while in HELD. A latched fired flag blocks re-firing until the next IDLE.
- Latency: with btn_in steady active from the edge at cycle k, press and btn_level rise in cycle k+DEBOUNCE_CYCLES+3. Release is symmetric.
- Simultaneous events:
  - press, release and long_press are mutually exclusive by construction.
  - If s drops in the same cycle hcnt hits its threshold, HELD→RELEASE_WAIT takes priority and long_press still fires. The count was met, and the bounce is not yet a release.

Decomposition:
- Shared package (button_pkg):
  - state enum {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - a clog2-based width helper for both counters.
- Sub-module sync2: a parameterised two-flop synchroniser with reset value input. Reusable by other pin inputs.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, ACTIVE_LOW=1):
- Reset, then btn_in held 1 for 50 cycles -> all outputs stay 0.
- btn_in driven 0 at cycle 10 and held -> press=1 only in cycle 17; btn_level=1 from 17; long_press=1 only in cycle 36.
- Press accepted, then btn_in pulses 1 for 2 cycles and returns to 0 -> btn_level stays 1, no release, no second press.
- Glitch: btn_in at 0 for 3 cycles, then back to 1 -> no press, btn_level stays 0.
- Press held 10 cycles after acceptance, then btn_in=1 steady -> release one cycle, 7 cycles after the release edge; no long_press.
- rst asserted in HELD -> next cycle all outputs 0 and no release pulse. With btn_in still 0, a fresh press fires DEBOUNCE_CYCLES+3 cycles after rst drops.
